cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the icache/dcache arbiter.
- Converts the arbiter's single-transfer 256-bit cache-line read/write into a 4-beat 64-bit burst on physical memory.
- Returns the assembled line and a one-cycle resp pulse to the arbiter.
- Upstream pins are named to match the arbiter's pmem side (read/write/address/wdata/rdata/resp/error).

Parameters:
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles between burst beats. Used only with TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- line_read  in  1  line read request from arbiter; held until line_resp.
- line_write  in  1  line write request from arbiter; held until line_resp.
- line_address  in  32  line byte address; bits [4:0] ignored.
- line_wdata  in  256  write line from arbiter.
- line_rdata  out  256  assembled read line; valid when line_resp=1.
- line_resp  out  1  one-cycle completion pulse.
- line_error  out  1  asserted with line_resp when the transfer failed.
- burst_read  out  1  burst read request to memory.
- burst_write  out  1  burst write request to memory.
- burst_address  out  32  burst base address, {line_address[31:5], 5'b0}.
- burst_wdata  out  64  current write beat.
- burst_resp  in  1  memory beat acknowledge, one per beat.
- burst_rdata  in  64  read beat; valid when burst_resp=1.
- burst_error  in  1  memory error; sampled every cycle during a burst.

Behaviour:
- Reset: async on rst_n=0.
  - FSM goes to IDLE.
  - All outputs clear: line_rdata=0, line_resp=0, line_error=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0.
  - Beat counter and watchdog clear.
  - Reset mid-burst abandons the burst; no resp is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - line_read=1 -> capture aligned address, go to READ.
  - Else line_write=1 -> capture address and all 256 bits of line_wdata, go to WRITE.
  - Both asserted -> read wins.
  - Upstream changes after capture have no effect.
- READ:
  - burst_read=1 held for the whole burst.
  - Each cycle with burst_resp=1 stores burst_rdata into line_rdata[64*k +: 64], k = beat counter 0..3, lowest beat first; k increments.
  - Accepting beat 3 -> go to DONE; burst_read drops the next cycle.
  - burst_resp=0 cycles are stalls; no state change.
- WRITE:
  - burst_write=1 held for the whole burst.
  - burst_wdata = captured line[64*k +: 64], held until burst_resp=1, then advances to k+1.
  - Accepting beat 3 -> go to DONE.
- Error: burst_error=1 in READ or WRITE aborts immediately.
  - burst_read and burst_write drop the next cycle.
  - Go to DONE with the error flag set.
  - line_rdata holds only partially updated data.
- DONE:
  - line_resp=1 for exactly one cycle; line_error = error flag.
  - Always return to IDLE; error flag clears.
- Latency: minimum 6 cycles from request to line_resp, given zero-wait memory (1 capture + 4 beats + 1 DONE).
- Back-to-back: upstream deasserts its request the cycle after line_resp. IDLE samples a new request the cycle after DONE, so there is no double-issue.
- Beat counter is 2 bits and wraps to 0 on entering DONE.
- line_rdata holds its value until the next read's beats overwrite it.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_TIMEOUT_EN.
- Defined:
  - A counter in READ/WRITE resets on each burst_resp and on state entry.
  - Reaching TIMEOUT_CYCLES consecutive cycles without burst_resp aborts exactly like burst_error: DONE with line_error=1, and burst request dropped.
- Undefined: no counter; the adaptor waits for burst_resp indefinitely.

Test Plan:
- Read, zero-wait: line_read=1, addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address=0x0000_1220; line_rdata={0x44..,0x33..,0x22..,0x11..}; line_resp pulse at cycle 6; line_error=0.
- Write with stalls: line_write=1, wdata={D3,D2,D1,D0}; burst_resp on cycles 3,4,7,8 -> burst_wdata shows D0,D1,D2,D3, each held until acked; one line_resp; burst_write low after the 4th ack.
- Error mid-read: burst_error=1 on beat 2 -> burst_read drops next cycle; line_resp=1 and line_error=1 together for one cycle; FSM back in IDLE.
- Reset mid-write: rst_n=0 after beat 1 -> all outputs 0 asynchronously; no line_resp; a subsequent line_read completes normally.
- Simultaneous line_read and line_write in IDLE -> burst_read=1, burst_write=0.
- Timeout (TIMEOUT_CYCLES=8, macro defined): no burst_resp for 8 cycles -> line_resp=1, line_error=1. Macro undefined: still waiting at 100 cycles.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// rtl/cacheline_adaptor_if.sv - arbiter-side line signals and memory-side burst signals
interface cacheline_adaptor_if;
    // Arbiter (upstream) side, single 256-bit line transfer
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         line_error;

    // Physical memory (downstream) side, 4 x 64-bit burst
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic         burst_resp;
    logic [63:0]  burst_rdata;
    logic         burst_error;

    // Adaptor view
    modport slave (
        input  line_read, line_write, line_address, line_wdata,
        output line_rdata, line_resp, line_error,
        output burst_read, burst_write, burst_address, burst_wdata,
        input  burst_resp, burst_rdata, burst_error
    );

    // Environment view (arbiter plus memory)
    modport master (
        output line_read, line_write, line_address, line_wdata,
        input  line_rdata, line_resp, line_error,
        input  burst_read, burst_write, burst_address, burst_wdata,
        output burst_resp, burst_rdata, burst_error
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit line to 4-beat 64-bit burst adaptor; optional watchdog via CACHELINE_ADAPTOR_TIMEOUT_EN
module cacheline_adaptor #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    cacheline_adaptor_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic [1:0]   r_state;
    logic [1:0]   r_beat;
    logic         r_err;
    logic [31:0]  r_addr;
    logic [255:0] r_wline;
    logic [255:0] r_rline;
    logic [31:0]  r_wdog;

    logic         w_busy;
    logic         w_timeout;
    logic         w_abort;
    logic [7:0]   w_beat_idx;

    assign w_busy     = (r_state == S_READ) || (r_state == S_WRITE);
    assign w_beat_idx = {r_beat, 6'd0};

    // The watchdog only fires on the Nth consecutive silent cycle; an ack in
    // the same cycle always wins so a late-but-valid beat is never discarded.
    assign w_timeout  = WDOG_ON && w_busy && !bus.burst_resp
                        && (r_wdog == TIMEOUT_CYCLES - 1);
    assign w_abort    = w_busy && (bus.burst_error || w_timeout);

    assign bus.burst_read    = (r_state == S_READ);
    assign bus.burst_write   = (r_state == S_WRITE);
    assign bus.burst_address = r_addr;
    assign bus.burst_wdata   = (r_state == S_WRITE) ? r_wline[w_beat_idx +: 64] : 64'd0;
    assign bus.line_rdata    = r_rline;
    assign bus.line_resp     = (r_state == S_DONE);
    assign bus.line_error    = (r_state == S_DONE) && r_err;

    // Transfer sequencer: capture request, stream four beats, pulse completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
            r_err   <= 1'b0;
            r_addr  <= 32'd0;
            r_wline <= 256'd0;
            r_rline <= 256'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat <= 2'd0;
                    if (bus.line_read) begin
                        r_addr  <= {bus.line_address[31:5], 5'd0};
                        r_state <= S_READ;
                    end else if (bus.line_write) begin
                        r_addr  <= {bus.line_address[31:5], 5'd0};
                        r_wline <= bus.line_wdata;
                        r_state <= S_WRITE;
                    end
                end
                S_READ, S_WRITE: begin
                    if (w_abort) begin
                        r_err   <= 1'b1;
                        r_beat  <= 2'd0;
                        r_state <= S_DONE;
                    end else if (bus.burst_resp) begin
                        if (r_state == S_READ) begin
                            r_rline[w_beat_idx +: 64] <= bus.burst_rdata;
                        end
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Upstream is still holding its request here; go straight
                    // to IDLE so the stale request is not re-issued.
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Inter-beat watchdog: counts consecutive silent burst cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 32'd0;
        end else if (!WDOG_ON || !w_busy || bus.burst_resp || w_timeout) begin
            r_wdog <= 32'd0;
        end else begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - randomized self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

    localparam int T_CYC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_adaptor_if bus ();

    cacheline_adaptor #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit           m_busy, m_rd, m_done, m_err;
    int           m_beats, m_stall;
    logic [31:0]  m_addr;
    logic [255:0] m_wline, m_rline;

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_done = 0; m_err = 0;
        m_beats = 0; m_stall = 0;
        m_addr = '0; m_wline = '0; m_rline = '0;
    endtask

    task automatic model_update();
        bit abort;
        abort = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
            m_err  = 0;
        end else if (!m_busy) begin
            if (bus.line_read || bus.line_write) begin
                m_busy  = 1;
                m_rd    = bus.line_read;
                m_addr  = {bus.line_address[31:5], 5'd0};
                m_beats = 0;
                m_stall = 0;
                if (!bus.line_read) m_wline = bus.line_wdata;
            end
        end else begin
            abort = bus.burst_error;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            if (!bus.burst_resp) begin
                m_stall++;
                if (m_stall >= T_CYC) abort = 1;
            end
`endif
            if (abort) begin
                m_busy = 0; m_done = 1; m_err = 1;
            end else if (bus.burst_resp) begin
                if (m_rd) m_rline[m_beats*64 +: 64] = bus.burst_rdata;
                m_beats++;
                m_stall = 0;
                if (m_beats == 4) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    endtask

    // every clock edge goes through here so the model sees each edge once
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("burst_read",    256'(bus.burst_read),    256'(m_busy && m_rd));
            check("burst_write",   256'(bus.burst_write),   256'(m_busy && !m_rd));
            check("burst_address", 256'(bus.burst_address), 256'(m_addr));
            check("line_resp",     256'(bus.line_resp),     256'(m_done));
            check("line_error",    256'(bus.line_error),    256'(m_done && m_err));
            check("line_rdata",    bus.line_rdata,          m_rline);
            if (m_busy && !m_rd)
                check("burst_wdata", 256'(bus.burst_wdata), 256'(m_wline[m_beats*64 +: 64]));
        end
    end

    // ---------------- stimulus ----------------
    int          resp_cyc, resp_cnt;
    bit          resp_err, resp_br, resp_bw, obs_br2, obs_bw2;
    logic [63:0] obs_wbeat [4];

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drop_all();
        bus.line_read = 0; bus.line_write = 0;
        bus.burst_resp = 0; bus.burst_error = 0;
    endtask

    // Drives one upstream request and plays memory. Cycle 1 is the request
    // cycle; bc counts burst cycles. mask bit i = ack on burst cycle quiet+i.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] wline, input logic [255:0] rsrc,
                           input bit use_mask, input logic [31:0] mask, input int quiet,
                           input int err_at, input int rst_at, input int stall_pct,
                           input int max_cyc);
        int n, bc;
        bit was_done, r, e;
        resp_cyc = -1; resp_cnt = 0; resp_err = 0; resp_br = 0; resp_bw = 0;
        n = 1; bc = 0;
        bus.line_read = rd; bus.line_write = wr;
        bus.line_address = addr; bus.line_wdata = wline;
        bus.burst_resp = 0; bus.burst_error = 0;
        while (1) begin
            was_done = m_done;
            step();
            n++;
            if (bus.line_resp) begin
                resp_cnt++; resp_cyc = n; resp_err = bus.line_error;
                resp_br = bus.burst_read; resp_bw = bus.burst_write;
            end
            if (n == 2) begin obs_br2 = bus.burst_read; obs_bw2 = bus.burst_write; end
            if (was_done) begin drop_all(); break; end
            if (n >= max_cyc) begin
                n_checks++; n_errors++;
                $display("FAIL txn_budget: no completion after %0d cycles, required fewer", n);
                drop_all();
                break;
            end
            if (m_busy) begin
                if (rst_at == bc) begin
                    #2 rst_n = 0;
                    #1;
                    check("rst_burst_read",    256'(bus.burst_read),    256'd0);
                    check("rst_burst_write",   256'(bus.burst_write),   256'd0);
                    check("rst_burst_address", 256'(bus.burst_address), 256'd0);
                    check("rst_burst_wdata",   256'(bus.burst_wdata),   256'd0);
                    check("rst_line_rdata",    bus.line_rdata,          256'd0);
                    check("rst_line_resp",     256'(bus.line_resp),     256'd0);
                    model_reset();
                    drop_all();
                    step(); step();
                    rst_n = 1;
                    break;
                end
                // upstream changes after capture must be ignored
                bus.line_address = $urandom;
                bus.line_wdata   = rand256();
                e = (bc == err_at);
                if (bc < quiet) r = 0;
                else if (use_mask) r = (bc - quiet < 32) ? mask[bc - quiet] : 1'b1;
                else r = ($urandom_range(99) >= stall_pct);
                if (e) r = 0;
                bus.burst_resp  = r;
                bus.burst_error = e;
                bus.burst_rdata = rsrc[m_beats*64 +: 64];
                if (r && !m_rd) obs_wbeat[m_beats] = bus.burst_wdata;
                bc++;
            end else begin
                bus.burst_resp = 0; bus.burst_error = 0;
            end
        end
    endtask

    logic [255:0] l1, wl, rr, exp3;
    logic [63:0]  d0, d1, d2, d3;

    initial begin
        model_reset();
        drop_all();
        bus.line_address = '0; bus.line_wdata = '0; bus.burst_rdata = '0;
        rst_n = 0;
        step();
        chk_en = 1;
        step();
        check("reset_line_resp",   256'(bus.line_resp),   256'd0);
        check("reset_burst_read",  256'(bus.burst_read),  256'd0);
        check("reset_burst_write", 256'(bus.burst_write), 256'd0);
        check("reset_line_rdata",  bus.line_rdata,        256'd0);
        rst_n = 1;
        step();

        // zero-wait read
        l1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        run_txn(1, 0, 32'h0000_1234, '0, l1, 1, 32'hFFFF_FFFF, 0, -1, -1, 0, 50);
        check("rd_resp_cycle", 256'(resp_cyc), 256'd6);
        check("rd_resp_count", 256'(resp_cnt), 256'd1);
        check("rd_resp_error", 256'(resp_err), 256'd0);
        check("rd_address",    256'(bus.burst_address), 256'h1220);
        check("rd_line",       bus.line_rdata, l1);

        // write with stalls: acks on cycles 3,4,7,8
        d0 = 64'hD0D0_0000_0000_00D0; d1 = 64'hD1D1_1111_1111_11D1;
        d2 = 64'hD2D2_2222_2222_22D2; d3 = 64'hD3D3_3333_3333_33D3;
        run_txn(0, 1, 32'h0000_8047, {d3, d2, d1, d0}, '0, 1, 32'h66, 0, -1, -1, 0, 50);
        check("wr_resp_cycle", 256'(resp_cyc), 256'd9);
        check("wr_resp_count", 256'(resp_cnt), 256'd1);
        check("wr_beat0", 256'(obs_wbeat[0]), 256'(d0));
        check("wr_beat1", 256'(obs_wbeat[1]), 256'(d1));
        check("wr_beat2", 256'(obs_wbeat[2]), 256'(d2));
        check("wr_beat3", 256'(obs_wbeat[3]), 256'(d3));
        check("wr_burst_write_in_done", 256'(resp_bw), 256'd0);
        check("wr_rdata_kept", bus.line_rdata, l1);

        // error on beat 2 of a read
        rr = rand256();
        run_txn(1, 0, 32'h00AB_CDE0, '0, rr, 1, 32'hFFFF_FFFF, 0, 2, -1, 0, 50);
        exp3 = {l1[255:128], rr[127:0]};
        check("err_resp_cycle", 256'(resp_cyc), 256'd5);
        check("err_flag",       256'(resp_err), 256'd1);
        check("err_resp_count", 256'(resp_cnt), 256'd1);
        check("err_burst_read_in_done", 256'(resp_br), 256'd0);
        check("err_partial_line", bus.line_rdata, exp3);
        step();
        check("err_idle_read", 256'(bus.burst_read), 256'd0);

        // reset after beat 1 of a write, then a normal read
        run_txn(0, 1, 32'h0000_4000, rand256(), '0, 1, 32'hFFFF_FFFF, 0, -1, 2, 0, 50);
        check("rstw_no_resp", 256'(resp_cnt), 256'd0);
        rr = rand256();
        run_txn(1, 0, 32'h0000_5000, '0, rr, 1, 32'hFFFF_FFFF, 0, -1, -1, 0, 50);
        check("rstw_read_cycle", 256'(resp_cyc), 256'd6);
        check("rstw_read_line",  bus.line_rdata, rr);

        // read and write together: read wins
        rr = rand256();
        run_txn(1, 1, 32'h0000_6000, rand256(), rr, 1, 32'hFFFF_FFFF, 0, -1, -1, 0, 50);
        check("both_burst_read",  256'(obs_br2), 256'd1);
        check("both_burst_write", 256'(obs_bw2), 256'd0);
        check("both_line",        bus.line_rdata, rr);

        // memory silent for 100 burst cycles
        rr = rand256();
        run_txn(1, 0, 32'h0000_7000, '0, rr, 0, '0, 100, -1, -1, 0, 300);
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        check("tmo_resp_cycle", 256'(resp_cyc), 256'd10);
        check("tmo_error",      256'(resp_err), 256'd1);
`else
        check("tmo_resp_cycle", 256'(resp_cyc), 256'd106);
        check("tmo_error",      256'(resp_err), 256'd0);
        check("tmo_line",       bus.line_rdata, rr);
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            int ea;
            rd = 1'($urandom_range(1));
            wr = rd ? 1'($urandom_range(1)) : 1'b1;
            ea = ($urandom_range(7) == 0) ? int'($urandom_range(5)) : -1;
            run_txn(rd, wr, $urandom, rand256(), rand256(), 0, '0, 0, ea, -1,
                    int'($urandom_range(60)), 400);
            check("rand_resp_count", 256'(resp_cnt), 256'd1);
            repeat ($urandom_range(2)) step();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
